// File: rtl/qsys_pio_in_debounce.sv
// Avalon-MM input PIO: per-bit synchroniser, consecutive-sample debouncer,
// edge capture (W1C) and maskable level interrupt.

module qsys_pio_in_debounce_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  input  logic prime_load_i,
  input  logic primed_i,
  output logic stable_o,
  output logic stable_dly_o
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    if (prime_load_i) begin
      // Load both so the first primed cycle never looks like an edge.
      stable_d     = sync;
      stable_dly_d = sync;
      cnt_d        = '0;
    end else if (primed_i) begin
      if (sync == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        stable_d = sync;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], in_i};
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_dly_o = stable_dly_q;
endmodule

module qsys_pio_in_debounce #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam bit CAP_RISE = (EDGE_TYPE != 1);
  localparam bit CAP_FALL = (EDGE_TYPE != 0);

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             primed_q, primed_d, prime_load;
  logic [WIDTH-1:0] stable, stable_dly, edge_hit, clr;
  logic [WIDTH-1:0] mask_q, mask_d, ecap_q, ecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  // Priming: let the synchroniser fill before trusting its output.
  always_comb begin
    pcnt_d     = pcnt_q;
    primed_d   = primed_q;
    prime_load = 1'b0;
    if (!primed_q) begin
      if (pcnt_q == PW'(SYNC_STAGES)) begin
        prime_load = 1'b1;
        primed_d   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      qsys_pio_in_debounce_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CW             (CW)
      ) u_lane (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_i        (in_port[gi]),
        .prime_load_i(prime_load),
        .primed_i    (primed_q),
        .stable_o    (stable[gi]),
        .stable_dly_o(stable_dly[gi])
      );
    end
  endgenerate

  assign edge_hit = {WIDTH{primed_q}} &
                    (({WIDTH{CAP_RISE}} & stable & ~stable_dly) |
                     ({WIDTH{CAP_FALL}} & ~stable & stable_dly));

  assign wr = chipselect & ~write_n;

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr && address == 2'd2) mask_d = writedata[WIDTH-1:0];
    if (wr && address == 2'd3) clr    = writedata[WIDTH-1:0];
    // A new edge beats a same-cycle clear.
    ecap_d = (ecap_q & ~clr) | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    if (chipselect) begin
      case (address)
        2'd0:    readdata_d = 32'(stable);
        2'd2:    readdata_d = 32'(mask_q);
        2'd3:    readdata_d = 32'(ecap_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q     <= '0;
      primed_q   <= 1'b0;
      mask_q     <= '0;
      ecap_q     <= '0;
      readdata_q <= '0;
    end else begin
      pcnt_q     <= pcnt_d;
      primed_q   <= primed_d;
      mask_q     <= mask_d;
      ecap_q     <= ecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(ecap_q & mask_q);
endmodule

// File: doc/qsys_pio_in_debounce.md
# qsys_pio_in_debounce

Parametrised Avalon-MM input PIO for board switches and push-buttons. Per bit, the block provides a synchroniser, a consecutive-sample debouncer, edge capture and a maskable level interrupt. It is a drop-in Qsys slave for the existing read-only switch ports and adds the behaviour those ports lack: metastability hardening, debouncing, edge latching and interrupts.

## Interface
- WIDTH, 16: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 50000: consecutive differing samples required before the debounced value changes, 1..2^20.
- EDGE_TYPE, 0: edges captured. 0 = rising, 1 = falling, 2 = both.

- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; valid only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- in_port  in  WIDTH  asynchronous raw inputs.
- irq  out  1  level interrupt to the Qsys IRQ receiver.

## Operation
- Register map:
  - address 0, DATA: read-only, returns the debounced value.
  - address 1: reserved, reads 0.
  - address 2, IRQMASK: read/write, bits [WIDTH-1:0].
  - address 3, EDGECAP: read returns captured edges; write-1-to-clear.
  - Writes to addresses 0 and 1 are ignored. Bits [31:WIDTH] of writes are ignored.
- Synchroniser: SYNC_STAGES-flop chain per bit. Its last stage is `sync`.
- Priming: after reset, a counter waits SYNC_STAGES cycles for the chain to fill. On the following edge, `stable` loads `sync` directly and `primed` goes to 1. No edge is captured and no debounce is applied during priming. Before priming completes, DATA reads 0.
- Debounce, one counter per bit, active when primed:
  - If `sync` == `stable`, the counter clears to 0.
  - If they differ and count == DEBOUNCE_CYCLES-1, `stable` <= `sync` and the counter clears.
  - Otherwise the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Edge detect: `stable_d` is `stable` delayed one cycle. A rising edge is stable & ~stable_d; a falling edge is ~stable & stable_d. The enabled edge types per EDGE_TYPE are OR-ed into EDGECAP.
- EDGECAP bits are sticky until cleared by a write of 1 to address 3 with chipselect and write_n low.
  - If a new edge and a clear hit the same bit on the same edge, set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers only, so it is glitch-free.
  - A mask write takes effect on irq the cycle after the write edge.
- Read: on every clk edge, readdata <= the selected register when chipselect=1, else 0. Read has no side effects.

## Timing
- Reset, asynchronous: readdata, irq, EDGECAP, IRQMASK, the synchroniser flops, stable, stable_d, the counters and primed are all 0.
- Read latency: 1 cycle. Data is valid the cycle after address/chipselect are sampled. No waitrequest.
- Write latency: 0 wait states. The register updates on the sampling edge.
- Input to DATA: take in_port changing cleanly and being sampled at edge E. `sync` changes at E+SYNC_STAGES-1 and `stable` at E+SYNC_STAGES-1+DEBOUNCE_CYCLES. EDGECAP sets one edge later, and irq rises in that same cycle if the bit is masked in.
- A bounce that returns `sync` to `stable` at any point restarts the full count.
- Reset asserted mid-debounce or with EDGECAP set clears everything. Priming then reruns, with no spurious edge even if inputs are high.
- Counter width: ceil(log2(DEBOUNCE_CYCLES)), minimum 1. With DEBOUNCE_CYCLES=1, `stable` tracks `sync` with one register of delay.

## Test plan
(WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.)
- Reset: in_port=16'hFFFF held through reset, then release -> DATA reads 0 until primed, then 0x0000FFFF; EDGECAP=0; irq=0 throughout.
- Rising edge: in_port bit 3 0->1 sampled at edge E -> DATA bit 3 set at E+5; EDGECAP=0x8 at E+6. With IRQMASK=0x8, irq=1 at E+6. Writing 0x8 to address 3 clears EDGECAP and drops irq the next cycle.
- Bounce: bit 0 toggles high 3 cycles, low 1, high 5 -> exactly one DATA transition, after the 5-cycle run; EDGECAP bit 0 set once.
- Simultaneous clear and set: issue a W1C write on the same edge that bit 2's edge capture occurs -> EDGECAP bit 2 remains 1.
- EDGE_TYPE=2, mask 0: a pulse of 10 cycles -> EDGECAP set; irq stays 0. Then write IRQMASK=0xFFFF -> irq=1 the next cycle. Read address 2 -> 0x0000FFFF; read address 1 -> 0.
- Reset mid-debounce: assert reset_n low at count 2 -> all outputs 0 immediately; after release, no edge is captured for the held input level.
